// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
// Time-multiplexed scan controller for an 8x8 LED matrix plus one 7+1
// segment digit that shares the column bus. A frame has 9 slots: slots 0-7
// each strobe one matrix row, and slot 8 enables the digit. Every slot
// starts with a blanking guard so that neither rows nor columns change while
// anything is lit. The frame is double-buffered. The bus writes only the
// back buffer. A swap request is held until the next frame boundary, so a
// displayed frame never tears.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   enable                scan enable; low blanks outputs and restarts scan
//   wr_valid/wr_ready     write handshake into back[wr_addr] (9-15 dropped)
//   wr_addr, wr_data      slot index and slot pattern
//   swap_req              request front/back swap at next frame boundary
//   row                   active-low row strobes (8'hFF = all off)
//   d                     active-high column/segment data
//   seven_seg             digit enable (slot 8 drive phase)
//   frame_start           1-cycle pulse in slot 0 cycle 0
//   swap_done             1-cycle pulse in the first cycle of a swapped frame
module led_matrix_scanner #(
  parameter int SLOT_CYCLES  = 3000,
  parameter int BLANK_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic [7:0] row,
  output logic [7:0] d,
  output logic       seven_seg,
  output logic       frame_start,
  output logic       swap_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);
  localparam logic [3:0]    SLOT_DIG = 4'd8;

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t          state_q, state_d;
  logic [3:0]      slot_q, slot_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            sel_q, sel_d;
  logic            pend_q, pend_d;
  logic [7:0]      buf_q [2][9];
  logic [7:0]      buf_d [2][9];
  logic            wr_ready_q;
  logic [7:0]      row_q, row_d;
  logic [7:0]      d_q, d_d;
  logic            seg_q, seg_d;
  logic            fs_q, fs_d;
  logic            sd_q, sd_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cyc_d   = cyc_q;
    sel_d   = sel_q;
    pend_d  = pend_q | swap_req;
    buf_d   = buf_q;
    sd_d    = 1'b0;

    // The write targets the pre-swap back buffer. If a swap takes effect at
    // the same edge, that buffer becomes the new front.
    if (wr_valid && wr_ready_q && (wr_addr < 4'd9))
      buf_d[!sel_q][wr_addr] = wr_data;

    if (!enable) begin
      state_d = ST_IDLE;
      slot_d  = 4'd0;
      cyc_d   = '0;
    end else if (state_q == ST_IDLE) begin
      // First enabled edge lands on slot 0 cycle 0.
      state_d = ST_SCAN;
      slot_d  = 4'd0;
      cyc_d   = '0;
    end else if (cyc_q == CYC_LAST) begin
      cyc_d = '0;
      if (slot_q == SLOT_DIG) begin
        slot_d = 4'd0;
        if (pend_d) begin
          sel_d  = !sel_q;
          pend_d = 1'b0;
          sd_d   = 1'b1;
        end
      end else begin
        slot_d = slot_q + 4'd1;
      end
    end else begin
      cyc_d = cyc_q + 1'b1;
    end

    // Outputs are computed from the next counter state, so the registered
    // values line up with the slot/cycle of the same cycle.
    row_d = 8'hFF;
    d_d   = 8'h00;
    seg_d = 1'b0;
    fs_d  = 1'b0;
    if (state_d == ST_SCAN) begin
      fs_d = (slot_d == 4'd0) && (cyc_d == '0);
      if (cyc_d >= BLANK_C) begin
        d_d = buf_d[sel_d][slot_d];
        if (slot_d == SLOT_DIG) seg_d = 1'b1;
        else                    row_d = ~(8'd1 << slot_d[2:0]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= 4'd0;
      cyc_q      <= '0;
      sel_q      <= 1'b0;
      pend_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      row_q      <= 8'hFF;
      d_q        <= 8'h00;
      seg_q      <= 1'b0;
      fs_q       <= 1'b0;
      sd_q       <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 9; i++)
          buf_q[b][i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      cyc_q      <= cyc_d;
      sel_q      <= sel_d;
      pend_q     <= pend_d;
      wr_ready_q <= 1'b1;
      row_q      <= row_d;
      d_q        <= d_d;
      seg_q      <= seg_d;
      fs_q       <= fs_d;
      sd_q       <= sd_d;
      buf_q      <= buf_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign row         = row_q;
  assign d           = d_q;
  assign seven_seg   = seg_q;
  assign frame_start = fs_q;
  assign swap_done   = sd_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;

  localparam int SC = 8;
  localparam int BC = 2;
  localparam int FR = 9 * SC;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'd0;
  logic       swap_req = 1'b0;
  logic       wr_ready;
  logic [7:0] row;
  logic [7:0] d;
  logic       seven_seg;
  logic       frame_start;
  logic       swap_done;

  led_matrix_scanner #(.SLOT_CYCLES(SC), .BLANK_CYCLES(BC)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .row(row), .d(d),
    .seven_seg(seven_seg), .frame_start(frame_start), .swap_done(swap_done)
  );

  always #5 clock = ~clock;

  // Reference model: frame position 0..FR-1, and two slot arrays whose
  // contents are exchanged on a swap.
  bit         m_run, m_rdy, m_pend, m_sd;
  int         m_pos;
  logic [7:0] m_front [9];
  logic [7:0] m_back  [9];
  int         phase;
  int         total, bad;

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_run = 0; m_rdy = 0; m_pend = 0; m_sd = 0; m_pos = 0;
        for (int i = 0; i < 9; i++) begin m_front[i] = 8'h00; m_back[i] = 8'h00; end
      end else begin
        bit pn;
        if (wr_valid && m_rdy && wr_addr < 9) m_back[wr_addr] = wr_data;
        pn = m_pend || swap_req;
        m_sd = 0;
        if (!enable) begin
          m_run = 0; m_pos = 0;
        end else if (!m_run) begin
          m_run = 1; m_pos = 0;
        end else if (m_pos == FR - 1) begin
          m_pos = 0;
          if (pn) begin
            for (int i = 0; i < 9; i++) begin
              logic [7:0] t;
              t = m_front[i]; m_front[i] = m_back[i]; m_back[i] = t;
            end
            pn = 0; m_sd = 1;
          end
        end else begin
          m_pos = m_pos + 1;
        end
        m_pend = pn;
        m_rdy = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t pos=%0d)", nm, act, exp, $time, m_pos);
    end
  endtask

  // Single compare process, on the inactive clock edge.
  initial begin
    forever begin
      logic [7:0] e_row, e_d;
      logic       e_seg, e_fs;
      int         s, c;
      @(negedge clock);
      e_row = 8'hFF; e_d = 8'h00; e_seg = 1'b0; e_fs = 1'b0;
      if (m_run) begin
        s = m_pos / SC; c = m_pos % SC;
        e_fs = (m_pos == 0);
        if (c >= BC) begin
          e_d = m_front[s];
          if (s < 8) e_row = 8'hFF ^ (8'h01 << s);
          else       e_seg = 1'b1;
        end
      end
      chk("row", row, e_row);
      chk("d", d, e_d);
      chk("seven_seg", {7'd0, seven_seg}, {7'd0, e_seg});
      chk("frame_start", {7'd0, frame_start}, {7'd0, e_fs});
      chk("swap_done", {7'd0, swap_done}, {7'd0, m_sd});
      chk("wr_ready", {7'd0, wr_ready}, {7'd0, m_rdy});
      // Hand-computed expectations pinning both DUT and model.
      if (phase == 0 || phase == 9) begin
        chk("lit_rst_row", row, 8'hFF);
        chk("lit_rst_d", d, 8'h00);
        chk("lit_rst_rdy", {7'd0, wr_ready}, 8'h00);
        chk("lit_rst_seg", {7'd0, seven_seg}, 8'h00);
      end
      if (phase == 2 && m_run && m_pos == 3) begin
        chk("lit_s0_row", row, 8'hFE); chk("lit_s0_d", d, 8'h81);
        chk("lit_s0_model", e_d, 8'h81);
      end
      if (phase == 2 && m_run && m_pos == 15) begin
        chk("lit_s1_row", row, 8'hFD); chk("lit_s1_d", d, 8'h3C);
        chk("lit_s1_model", e_d, 8'h3C);
      end
      if (phase == 2 && m_run && m_pos == 9) begin
        chk("lit_s1_blank_row", row, 8'hFF); chk("lit_s1_blank_d", d, 8'h00);
      end
      if (phase == 4 && m_run && m_pos == 70) begin
        chk("lit_dig_row", row, 8'hFF); chk("lit_dig_d", d, 8'h6D);
        chk("lit_dig_seg", {7'd0, seven_seg}, 8'h01);
        chk("lit_dig_model", e_d, 8'h6D);
      end
      if (phase == 10 && m_run && m_pos == 3) begin
        chk("lit_post_rst_d", d, 8'h00);
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v);
    wr_valid = 1'b1; wr_addr = a; wr_data = v;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 4 * FR && !(m_run && m_pos == p); i++) tick();
  endtask

  task automatic wait_swap();
    for (int i = 0; i < 4 * FR && !m_sd; i++) tick();
  endtask

  initial begin
    total = 0; bad = 0; phase = 0;
    repeat (3) tick();
    reset_n = 1'b1; enable = 1'b1; phase = 1;
    repeat (2 * FR + 5) tick();

    // Row display
    wr(4'd0, 8'h81); wr(4'd1, 8'h3C); pulse_swap();
    wait_swap(); phase = 2;
    repeat (FR) tick();
    phase = 3;

    // Digit slot and dropped address
    wr(4'd8, 8'h6D); wr(4'd12, 8'hFF); pulse_swap();
    wait_swap(); phase = 4;
    repeat (FR) tick();
    phase = 5;

    // Triple request within one frame, then swap back
    wait_pos(5);
    pulse_swap(); tick(); pulse_swap(); tick(); pulse_swap();
    wait_swap(); repeat (FR + 3) tick();
    pulse_swap(); wait_swap(); repeat (FR) tick();

    // Write plus swap request on the boundary edge
    wait_pos(FR - 1);
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 8'h5A; swap_req = 1'b1;
    tick();
    wr_valid = 1'b0; swap_req = 1'b0;
    repeat (FR + 4) tick();

    // Enable gating in slot 3 drive, with a swap request while disabled
    wait_pos(3 * SC + 4);
    enable = 1'b0;
    tick(); pulse_swap(); repeat (4) tick();
    enable = 1'b1;
    repeat (2 * FR + 3) tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(3) == 0);
      wr_addr  = 4'($urandom_range(15));
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(19) == 0);
      if ($urandom_range(149) == 0) enable = ~enable;
      else if (!enable && $urandom_range(3) == 0) enable = 1'b1;
      tick();
    end
    wr_valid = 1'b0; swap_req = 1'b0; enable = 1'b1;
    pulse_swap(); wait_swap(); repeat (FR) tick();

    // Asynchronous reset mid slot 5 drive
    wait_pos(5 * SC + 3);
    @(posedge clock); #2;
    reset_n = 1'b0; phase = 9;
    repeat (2) tick();
    reset_n = 1'b1; phase = 10;
    repeat (2 * FR) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
